// File: rtl/text_console_pkg.sv
// Shared constants, control codes and FSM state type for the text console writer.
package text_console_pkg;

    localparam int unsigned DefaultCols = 80;
    localparam int unsigned DefaultRows = 25;

    localparam logic [7:0] CharBs = 8'h08;
    localparam logic [7:0] CharLf = 8'h0A;
    localparam logic [7:0] CharFf = 8'h0C;
    localparam logic [7:0] CharCr = 8'h0D;

    localparam logic [31:0] FillWord = 32'h2020_2020;

    typedef enum logic [1:0] {
        StClrScreen,
        StIdle,
        StClrLine
    } state_e;

    function automatic logic is_printable(input logic [7:0] c);
        return (c >= 8'h20) && (c <= 8'h7E);
    endfunction

endpackage

// File: rtl/text_console_writer_if.sv
// Character input handshake plus text RAM write port and status of the console writer.
interface text_console_writer_if;

    logic        char_valid;
    logic [7:0]  char_data;
    logic        char_ready;
    logic [8:0]  write_address;
    logic [31:0] write_data;
    logic [3:0]  write_byteena;
    logic        write_en;
    logic [6:0]  cursor_col;
    logic [4:0]  cursor_row;
    logic        busy;

    modport master (
        output char_valid, char_data,
        input  char_ready, write_address, write_data, write_byteena, write_en,
        input  cursor_col, cursor_row, busy
    );

    modport slave (
        input  char_valid, char_data,
        output char_ready, write_address, write_data, write_byteena, write_en,
        output cursor_col, cursor_row, busy
    );

endinterface

// File: rtl/text_console_writer.sv
// Writes a character stream into a word-organised text RAM, tracking a cursor and
// clearing lines on row advance and the whole screen on form feed or reset.
module text_console_writer
    import text_console_pkg::*;
#(
    parameter int unsigned COLS = DefaultCols,
    parameter int unsigned ROWS = DefaultRows
) (
    input logic                  clk,
    input logic                  reset,
    text_console_writer_if.slave bus
);

    localparam int unsigned LineWords   = COLS / 4;
    localparam int unsigned ScreenWords = (ROWS * COLS) / 4;

    localparam logic [8:0]  LineLast   = 9'(LineWords - 1);
    localparam logic [8:0]  ScreenLast = 9'(ScreenWords - 1);
    localparam logic [8:0]  LineW      = 9'(LineWords);
    localparam logic [10:0] ColsW      = 11'(COLS);
    localparam logic [6:0]  ColLast    = 7'(COLS - 1);
    localparam logic [4:0]  RowLast    = 5'(ROWS - 1);

    state_e      state;
    logic [8:0]  clr_cnt;
    logic [6:0]  col_q;
    logic [4:0]  row_q;
    logic        wen_q;
    logic [8:0]  waddr_q;
    logic [31:0] wdata_q;
    logic [3:0]  wbe_q;

    logic [10:0] cell_index;
    logic [4:0]  row_next;
    logic [8:0]  line_base;
    logic [8:0]  next_line_base;
    logic [7:0]  c;

    assign c              = bus.char_data;
    assign cell_index     = 11'(row_q) * ColsW + 11'(col_q);
    assign row_next       = (row_q == RowLast) ? 5'd0 : row_q + 5'd1;
    assign line_base      = 9'(row_q) * LineW;
    assign next_line_base = 9'(row_next) * LineW;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state   <= StClrScreen;
            clr_cnt <= '0;
            col_q   <= '0;
            row_q   <= '0;
            wen_q   <= 1'b0;
            waddr_q <= '0;
            wdata_q <= '0;
            wbe_q   <= '0;
        end else begin
            wen_q <= 1'b0;
            unique case (state)
                StClrScreen: begin
                    wen_q   <= 1'b1;
                    waddr_q <= clr_cnt;
                    wdata_q <= FillWord;
                    wbe_q   <= 4'hF;
                    if (clr_cnt == ScreenLast) begin
                        clr_cnt <= '0;
                        state   <= StIdle;
                    end else begin
                        clr_cnt <= clr_cnt + 9'd1;
                    end
                end
                StClrLine: begin
                    wen_q   <= 1'b1;
                    waddr_q <= line_base + clr_cnt;
                    wdata_q <= FillWord;
                    wbe_q   <= 4'hF;
                    if (clr_cnt == LineLast) begin
                        clr_cnt <= '0;
                        state   <= StIdle;
                    end else begin
                        clr_cnt <= clr_cnt + 9'd1;
                    end
                end
                StIdle: begin
                    if (bus.char_valid) begin
                        if (is_printable(c)) begin
                            wen_q   <= 1'b1;
                            waddr_q <= cell_index[10:2];
                            wdata_q <= {4{c}};
                            wbe_q   <= 4'b0001 << cell_index[1:0];
                            if (col_q == ColLast) begin
                                // Line clear follows the character write on the next cycle.
                                col_q   <= '0;
                                row_q   <= row_next;
                                clr_cnt <= '0;
                                state   <= StClrLine;
                            end else begin
                                col_q <= col_q + 7'd1;
                            end
                        end else begin
                            case (c)
                                CharCr: col_q <= '0;
                                CharLf: begin
                                    // No character write to emit, so the first clear word goes out now.
                                    col_q   <= '0;
                                    row_q   <= row_next;
                                    wen_q   <= 1'b1;
                                    waddr_q <= next_line_base;
                                    wdata_q <= FillWord;
                                    wbe_q   <= 4'hF;
                                    clr_cnt <= 9'd1;
                                    state   <= StClrLine;
                                end
                                CharBs: begin
                                    if (col_q != 7'd0) begin
                                        col_q <= col_q - 7'd1;
                                    end
                                end
                                CharFf: begin
                                    col_q   <= '0;
                                    row_q   <= '0;
                                    clr_cnt <= '0;
                                    state   <= StClrScreen;
                                end
                                default: ;
                            endcase
                        end
                    end
                end
                default: state <= StClrScreen;
            endcase
        end
    end

    assign bus.char_ready    = (state == StIdle);
    assign bus.busy          = (state != StIdle);
    assign bus.write_en      = wen_q;
    assign bus.write_address = waddr_q;
    assign bus.write_data    = wdata_q;
    assign bus.write_byteena = wbe_q;
    assign bus.cursor_col    = col_q;
    assign bus.cursor_row    = row_q;

endmodule

// File: doc/text_console_writer.md
TEXT_CONSOLE_WRITER -- requirements
Module: text_console_writer

Interface
REQ-001 The block SHALL have parameter COLS, default 80, meaning characters per text row.
REQ-002 The block SHALL have parameter ROWS, default 25, meaning text rows per screen.
REQ-003 The block SHALL have port clk, input, 1, single clock for all logic.
REQ-004 The block SHALL have port reset, input, 1, asynchronous active-high reset.
REQ-005 The block SHALL have port char_valid, input, 1, character byte offered.
REQ-006 The block SHALL have port char_data, input, 8, character code.
REQ-007 The block SHALL have port char_ready, output, 1, block accepts char_data this cycle.
REQ-008 The block SHALL have port write_address, output, 9, text RAM word address.
REQ-009 The block SHALL have port write_data, output, 32, text RAM write word.
REQ-010 The block SHALL have port write_byteena, output, 4, byte enables; bit n selects write_data[8n+7:8n].
REQ-011 The block SHALL have port write_en, output, 1, one-cycle text RAM write strobe.
REQ-012 The block SHALL have ports cursor_col (7) and cursor_row (5), outputs, current cursor position.
REQ-013 The block SHALL have port busy, output, 1, high while a clear operation runs.

Function
REQ-014 Cell byte index SHALL be row*COLS+col; word address = index[10:2]; lane = index[1:0].
REQ-015 A character SHALL be accepted only in a cycle where char_valid and char_ready are both high.
REQ-016 char_ready SHALL equal (state == IDLE); one character per cycle SHALL be sustainable in IDLE.
REQ-017 States: CLR_SCREEN, IDLE, CLR_LINE; all write outputs SHALL be registered.
REQ-018 Printable codes 0x20-0x7E SHALL produce, the cycle after acceptance, write_en=1, write_byteena one-hot on the cursor lane, write_data = the code replicated in all four bytes.
REQ-019 After a printable, col SHALL increment; at col COLS-1 it SHALL become 0 and row SHALL advance.
REQ-020 0x0D SHALL set col=0 with no write.
REQ-021 0x0A SHALL set col=0 and advance row with no write.
REQ-022 0x08 SHALL decrement col when col>0, with no write; at col=0 it SHALL do nothing.
REQ-023 0x0C SHALL set cursor to (0,0) and enter CLR_SCREEN.
REQ-024 All other codes (0x00-0x07, 0x09, 0x0B, 0x0E-0x1F, 0x7F-0xFF) SHALL be consumed and ignored.
REQ-025 Row advance from row < ROWS-1 SHALL increment row; from ROWS-1 it SHALL set row=0 and enter CLR_LINE for row 0 (wrap, no scroll).
REQ-026 Every row advance SHALL enter CLR_LINE for the new row.
REQ-027 CLR_LINE SHALL issue COLS/4 (20) consecutive word writes, one per cycle, at addresses row*20 .. row*20+19, with write_data=32'h20202020 and write_byteena=4'hF, then return to IDLE.
REQ-028 The first CLR_LINE write SHALL occur in the cycle after the printable write or control acceptance that caused it.
REQ-029 CLR_SCREEN SHALL issue 500 consecutive word writes, addresses 0..499, data 32'h20202020, byteena 4'hF, then return to IDLE.
REQ-030 busy SHALL be high in CLR_SCREEN and CLR_LINE, and low in IDLE.
REQ-031 write_en SHALL be low in every cycle without a write described above.
REQ-032 The cursor outputs SHALL reflect the updated position from the cycle after acceptance.

Reset
REQ-033 While reset is high: write_en=0, write_address=0, write_data=0, write_byteena=0, cursor=(0,0), char_ready=0, busy=1, state=CLR_SCREEN.
REQ-034 On reset release, the block SHALL perform a full CLR_SCREEN before asserting char_ready.
REQ-035 Reset asserted mid-operation SHALL abort it immediately; the clear SHALL restart from address 0.

Structure
REQ-036 A shared package text_console_pkg SHALL hold COLS/ROWS defaults, the control codes (CR, LF, BS, FF), the fill word 32'h20202020 and the state enum.
REQ-037 No sub-module is required; cursor, address and FSM logic SHALL reside in text_console_writer.

Verification
REQ-038 Release reset -> 500 writes at addresses 0..499 with 32'h20202020/4'hF, then char_ready=1, cursor (0,0).
REQ-039 Send 'A' (0x41) at (0,0), then 'B' -> writes at addr 0 with byteena 4'b0001 and data 32'h41414141, then addr 0 with byteena 4'b0010; cursor (2,0).
REQ-040 Put cursor at (79,24) and send 0x5A -> write at addr 499 with byteena 4'b1000, cursor (0,0), busy=1, then 20 writes at addresses 0..19.
REQ-041 At (5,3), send 0x0D, 0x0A, 0x08 -> cursor (0,3), (0,4) with 20 clears at addresses 80..99, (0,4) unchanged.
REQ-042 Send 0x0C mid-screen, then pulse reset at the 100th clear write -> write_en drops immediately; after release the clear restarts at address 0.
REQ-043 Send 0x07 and 0xC3 back-to-back -> both are accepted with no write and no cursor change.
